// File: rtl/kamus_id_queue_pkg.sv
// rtl/kamus_id_queue_pkg.sv - shared decode types, opcode/funct/CSR enums and queue entry types
package kamus_id_queue_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [6:0] {
        F7_BASE = 7'b0000000,
        F7_ALT  = 7'b0100000
    } funct7_e;

    typedef enum logic [2:0] {
        CSR_PRIV = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_BAD  = 3'b100,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_op_e;

    typedef enum logic [5:0] {
        OP_INVALID, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
    } op_e;

    // pc is carried at full XLEN; narrower PCs are zero-extended into it.
    typedef struct packed {
        op_e              operation;
        logic [XLEN-1:0]  immediate;
        logic             immediate_used;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [XLEN-1:0]  pc;
    } instr_decoded_t;

    typedef enum logic {
        RUN,
        HALTED
    } id_state_e;

    typedef struct packed {
        instr_decoded_t instr;
        logic           illegal;
        logic           fetch_err;
    } id_entry_t;

endpackage

// File: rtl/kamus_id_core.sv
// rtl/kamus_id_core.sv - combinational RV32I + Zicsr/priv decoder
//
// Ports:
//   instr_i   raw 32-bit instruction word
//   pc_i      PC of the word
//   decoded_o decoded fields; operation is OP_INVALID for anything unrecognised
module kamus_id_core
    import kamus_id_queue_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic [31:0]         instr_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    output instr_decoded_t      decoded_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr, imm_shamt;
    op_e         op;
    logic [31:0] imm;
    logic        imm_used;

    assign opcode    = instr_i[6:0];
    assign f3        = instr_i[14:12];
    assign f7        = instr_i[31:25];
    assign imm_i     = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b     = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u     = {instr_i[31:12], 12'b0};
    assign imm_j     = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_csr   = {20'b0, instr_i[31:20]};
    assign imm_shamt = {27'b0, instr_i[24:20]};

    // Every opcode_e value has LSBs 2'b11, so compressed/garbage words fall to default.
    always_comb begin
        op       = OP_INVALID;
        imm      = '0;
        imm_used = 1'b0;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   imm = imm_u; imm_used = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; imm = imm_u; imm_used = 1'b1; end
            OPC_JAL:   begin op = OP_JAL;   imm = imm_j; imm_used = 1'b1; end
            OPC_JALR: begin
                imm = imm_i; imm_used = 1'b1;
                if (f3 == 3'b000) op = OP_JALR;
            end
            OPC_BRANCH: begin
                imm = imm_b; imm_used = 1'b1;
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_INVALID;
                endcase
            end
            OPC_LOAD: begin
                imm = imm_i; imm_used = 1'b1;
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_INVALID;
                endcase
            end
            OPC_STORE: begin
                imm = imm_s; imm_used = 1'b1;
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_INVALID;
                endcase
            end
            OPC_OP_IMM: begin
                imm = imm_i; imm_used = 1'b1;
                case (f3)
                    3'b000: op = OP_ADD;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b110: op = OP_OR;
                    3'b111: op = OP_AND;
                    // shamt[5] lives in f7[0], so any nonzero stray bit makes it illegal on RV32
                    3'b001: begin
                        imm = imm_shamt;
                        if (f7 == F7_BASE) op = OP_SLL;
                    end
                    default: begin
                        imm = imm_shamt;
                        if (f7 == F7_BASE)     op = OP_SRL;
                        else if (f7 == F7_ALT) op = OP_SRA;
                    end
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      op = OP_SUB;
                    else if (f3 == 3'b101) op = OP_SRA;
                end
            end
            OPC_MISC_MEM: begin
                if (f3 == 3'b000) op = OP_FENCE;
            end
            OPC_SYSTEM: begin
                case (csr_op_e'(f3))
                    CSR_PRIV: begin
                        case (instr_i)
                            32'h0000_0073: op = OP_ECALL;
                            32'h0010_0073: op = OP_EBREAK;
                            32'h3020_0073: op = OP_MRET;
                            32'h1050_0073: op = OP_WFI;
                            default:       op = OP_INVALID;
                        endcase
                    end
                    CSR_RW:  op = OP_CSRRW;
                    CSR_RS:  op = OP_CSRRS;
                    CSR_RC:  op = OP_CSRRC;
                    CSR_RWI: op = OP_CSRRWI;
                    CSR_RSI: op = OP_CSRRSI;
                    CSR_RCI: op = OP_CSRRCI;
                    default: op = OP_INVALID;
                endcase
                // CSR ops carry the CSR address as their immediate
                if (f3 != 3'b000) begin
                    imm = imm_csr; imm_used = 1'b1;
                end
            end
            default: op = OP_INVALID;
        endcase
        if (op == OP_INVALID) begin
            imm      = '0;
            imm_used = 1'b0;
        end
    end

    always_comb begin
        decoded_o                = '0;
        decoded_o.operation      = op;
        decoded_o.immediate      = imm;
        decoded_o.immediate_used = imm_used;
        decoded_o.rd             = instr_i[11:7];
        decoded_o.rs1            = instr_i[19:15];
        decoded_o.rs2            = instr_i[24:20];
        decoded_o.func3          = f3;
        decoded_o.func7          = f7;
        decoded_o.pc             = XLEN'(pc_i);
    end

endmodule

// File: rtl/kamus_id_queue.sv
// rtl/kamus_id_queue.sv - buffered decode stage: decode on enqueue, DEPTH-entry FIFO, halt on trap
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   flush_i              drop all entries and return to RUN
//   fetch_valid_i/ready_o, fetch_instr_i, fetch_pc_i, fetch_err_i   fetch-side handshake
//   issue_valid_o/ready_i, issue_instr_o, issue_illegal_o, issue_fetch_err_o   issue-side handshake
//   count_o              current occupancy
module kamus_id_queue
    import kamus_id_queue_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [31:0]                fetch_instr_i,
    input  logic [PC_WIDTH-1:0]        fetch_pc_i,
    input  logic                       fetch_err_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output instr_decoded_t             issue_instr_o,
    output logic                       issue_illegal_o,
    output logic                       issue_fetch_err_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    instr_decoded_t   dec;
    id_entry_t        new_entry;
    id_entry_t        head;
    id_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    id_state_e        state_q, state_d;
    logic             enq, deq;

    kamus_id_core #(.PC_WIDTH(PC_WIDTH)) u_core (
        .instr_i   (fetch_instr_i),
        .pc_i      (fetch_pc_i),
        .decoded_o (dec)
    );

    // A bus fault masks whatever the word happened to decode to.
    always_comb begin
        new_entry           = '0;
        new_entry.instr     = dec;
        new_entry.fetch_err = fetch_err_i;
        new_entry.illegal   = !fetch_err_i && (dec.operation == OP_INVALID);
    end

    assign fetch_ready_o = (state_q == RUN) && (count_q < CNT_W'(DEPTH)) && !flush_i;
    assign issue_valid_o = (count_q != '0) && !flush_i;
    assign enq           = fetch_valid_i && fetch_ready_o;
    assign deq           = issue_valid_o && issue_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (new_entry.illegal || new_entry.fetch_err) state_d = HALTED;
            end
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (deq && !enq) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= new_entry;
    end

    assign head              = mem_q[rd_ptr_q];
    assign issue_instr_o     = head.instr;
    assign issue_illegal_o   = issue_valid_o && head.illegal;
    assign issue_fetch_err_o = issue_valid_o && head.fetch_err;
    assign count_o           = count_q;

endmodule

// File: doc/kamus_id_queue.md
# kamus_id_queue

Registered, buffered instruction-decode stage that sits between fetch and issue. It accepts raw 32-bit RV32 instruction words with their PCs over a valid/ready handshake and decodes each one into `instr_decoded_t` at enqueue time. Decoded entries are held in a DEPTH-entry FIFO and presented to issue over a second valid/ready handshake. It adds flush support, illegal-instruction and fetch-fault tagging, and a halt-on-trap mode that blocks further speculative fetches until the pipeline flushes.

## Interface
Parameters:
- `PC_WIDTH`, default 32: width of the PC carried with each entry.
- `DEPTH`, default 4: number of FIFO entries; must be a power of two and at least 2.

Ports (clock and reset first):
- `clk_i` input 1: clock. This block has one clock; reset is synchronous and active-low.
- `rst_ni` input 1: synchronous, active-low reset.
- `flush_i` input 1: discard all entries and leave HALTED.
- `fetch_valid_i` input 1: fetch presents a word.
- `fetch_ready_o` output 1: the queue can accept a word.
- `fetch_instr_i` input 32: raw instruction word.
- `fetch_pc_i` input PC_WIDTH: PC of the word.
- `fetch_err_i` input 1: bus fault on this fetch.
- `issue_valid_o` output 1: the head entry is valid.
- `issue_ready_i` input 1: issue consumes the head entry.
- `issue_instr_o` output `instr_decoded_t`: decoded head entry.
- `issue_illegal_o` output 1: the head entry decoded to INVALID.
- `issue_fetch_err_o` output 1: the head entry carries a fetch fault.
- `count_o` output $clog2(DEPTH+1): current occupancy.

## Operation
- Decoding uses the standard RV32I base plus Zicsr/priv rules. The operation, immediate, immediate_used, rd, rs1, rs2, func3, func7 and pc fields are computed combinationally from `fetch_instr_i`/`fetch_pc_i` and written into the entry on enqueue.
- `illegal` is set for an entry when its decoded operation is INVALID (this includes two LSBs not equal to 2'b11, bad funct3, shift-amount bit 5 set, and an illegal CSR op). `illegal` is forced to 0 when `fetch_err_i` is set. In that case `fetch_err` is set and the decoded fields are don't-care.
- Enqueue fires when `fetch_valid_i && fetch_ready_o`. Dequeue fires when `issue_valid_o && issue_ready_i`.
- `fetch_ready_o = (state == RUN) && (count < DEPTH) && !flush_i`. There is no same-cycle pass-through when the queue is full.
- `issue_valid_o = (count != 0) && !flush_i`.
- State machine:
  - RUN: normal operation.
  - HALTED: entered on the clock edge that enqueues an entry with `illegal` or `fetch_err` set. In HALTED, `fetch_ready_o` is 0; dequeue continues so the trapping entry and any older entries drain.
  - HALTED goes to RUN only on `flush_i`.
- Flush has priority over enqueue and dequeue. In the cycle `flush_i` is high, no enqueue or dequeue takes effect. Next cycle: count 0, read and write pointers 0, state RUN.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is updated as +1 on enqueue only, -1 on dequeue only, and unchanged on simultaneous enqueue and dequeue.
- Ordering is strict FIFO.

## Timing
- Reset (`rst_ni` low at a clock edge) gives: state RUN, count_o 0, pointers 0, issue_valid_o 0, fetch_ready_o 1 (once `rst_ni` is high and `flush_i` is low), issue_illegal_o 0, issue_fetch_err_o 0. Entry storage is not reset.
- Reset mid-operation discards all entries on that edge. It overrides flush and any handshakes.
- Enqueue-to-issue latency: an entry enqueued at edge N is visible on `issue_*` after edge N, i.e. 1 cycle.
- `issue_*` data is stable while `issue_valid_o && !issue_ready_i`.
- Full (count == DEPTH): `fetch_ready_o` is 0, and a dequeue in that cycle reopens ready on the next cycle.
- Empty: `issue_valid_o` is 0 and `issue_*` data is don't-care.
- The HALTED transition and the enqueue of the trapping entry occur on the same edge. `fetch_ready_o` is 0 from the next cycle.

## Structure
- Shared package additions:
  - `id_state_e` {RUN, HALTED}.
  - `id_entry_t` {`instr_decoded_t` instr; logic illegal; logic fetch_err}.
- The existing opcode/funct/CSR enums and the `instr_decoded_t` type remain in the shared package.
- Sub-module: `kamus_id_core`, a purely combinational decoder (instr, pc -> `instr_decoded_t`), instantiated once on the fetch side.
- The FIFO storage, pointers, counter and FSM live in `kamus_id_queue`.

## Test plan
1. Single decode: reset, then enqueue 0x00500093 (addi x1,x0,5) at pc 0x100 with issue_ready_i=1.
   - Next cycle: issue_valid_o=1, operation ADD, imm 5, immediate_used=1, rd 1, pc 0x100, issue_illegal_o=0.
   - Following cycle: count_o returns to 0.
2. Fill and drain with DEPTH=4 and issue_ready_i=0.
   - Offer 6 words at pcs 0x0, 0x4, 0x8, ...: exactly 4 accepted, count_o=4, fetch_ready_o=0.
   - Raise issue_ready_i: pcs 0x0, 0x4, 0x8, 0xC issue in order, then fetch_ready_o=1.
3. Simultaneous enqueue and dequeue at count 2: count_o stays 2, and FIFO order is preserved across pointer wrap (run for 10 cycles).
4. Illegal word and fault:
   - Enqueue 0x00000000: the entry issues with issue_illegal_o=1, state goes HALTED, and fetch_ready_o=0 from the next cycle while older entries still drain.
   - Enqueue any word with fetch_err_i=1: issue_fetch_err_o=1 and issue_illegal_o=0.
5. Flush priority:
   - At count 3 with fetch_valid_i=1 and issue_ready_i=1, assert flush_i for one cycle.
   - Same cycle: issue_valid_o=0 and fetch_ready_o=0.
   - Next cycle: count_o=0, state RUN, and the offered word is not stored.
   - Also check that flush_i exits HALTED.
6. Reset mid-operation: drive rst_ni low for one edge at count 3 in HALTED. Next cycle: count_o=0, issue_valid_o=0, state RUN, fetch_ready_o=1.
